// File: rtl/read_control_pkg.sv
// Shared types and widths for the read_control slice (RAM drain toward the event builder).
package read_control_pkg;

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 32;
  localparam int LEN_W  = 10;
  localparam int CNT_W  = 5;

  localparam logic [DATA_W-1:0] HEADER_WORD = 16'hC0DE;

  // Writer-mirrored base step; the sum is kept one bit wider so a carry forces the wrap.
  function automatic logic [ADDR_W-1:0] next_base(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  half,
                                                  input logic [ADDR_W-1:0] depth);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + {{(ADDR_W + 1 - LEN_W){1'b0}}, half};
    return (sum >= {1'b0, depth}) ? '0 : sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/read_control_rd_return_fifo.sv
// Return-data FIFO: absorbs RAM words already in flight when the stream stalls.
module rd_return_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/read_control.sv
// Drains completed packages from the even/odd RAM pair as {odd,even} words on a valid/ready stream.
// Optional HEADER_CHECK_EN adds a sticky word-0 header comparator (hdr_err tied 0 otherwise).
module read_control
  import read_control_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int MAX_PKG    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              live_rising,
  input  logic              complete,
  input  logic [LEN_W-1:0]  HALF_PACKAGE_LENGTH,
  input  logic [ADDR_W-1:0] MEMORY_DEPTH,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] even_q,
  input  logic [DATA_W-1:0] odd_q,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  pkg_pending,
  output logic              overflow,
  output logic              hdr_err
);

  localparam int FC_W = $clog2(FIFO_DEPTH + 1);

  state_t            state, state_nxt;
  logic              init, xfer, pkg_done, avail, avail_next, issue, issue_last;
  logic [LEN_W-1:0]  half_q, w;
  logic [ADDR_W-1:0] depth_q, base;
  logic [CNT_W-1:0]  open_cnt;
  logic [RD_LATENCY:1] vld_pipe, last_pipe;
  logic [7:0]        inflight;
  logic [FC_W-1:0]   fifo_count;
  logic [OUT_W:0]    head;

  assign init       = rst | live_rising;
  assign xfer       = out_valid & out_ready;
  assign pkg_done   = xfer & out_last;
  assign issue_last = (w == half_q - LEN_W'(1));
  assign rd_addr    = base + {{(ADDR_W - LEN_W){1'b0}}, w};

  // open_cnt: packages whose addresses are all issued but whose last word has not left yet.
  // Reading runs ahead into the next stored package so package boundaries cost no bubble.
  assign avail      = pkg_pending > open_cnt;
  assign avail_next = {1'b0, pkg_pending} > ({1'b0, open_cnt} + 6'd1);

  always_ff @(posedge clk) begin
    if (init) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (avail && half_q != '0) state_nxt = READ;
      READ:    if (issue && issue_last) state_nxt = avail_next ? READ : FLUSH;
      FLUSH:   if (avail) state_nxt = READ;
               else if (open_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue only while every in-flight word is guaranteed a FIFO slot on return.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= RD_LATENCY; k++) inflight = inflight + {7'd0, vld_pipe[k]};
    issue = (state == READ) && !init && ((8'(fifo_count) + inflight) < 8'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_q  <= '0;
      depth_q <= '0;
    end else if (live_rising) begin
      half_q  <= HALF_PACKAGE_LENGTH;
      depth_q <= MEMORY_DEPTH;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      w        <= '0;
      base     <= '0;
      open_cnt <= '0;
    end else begin
      if (issue) begin
        w <= issue_last ? '0 : w + LEN_W'(1);
        if (issue_last) base <= next_base(base, half_q, depth_q);
      end
      case ({issue && issue_last, pkg_done})
        2'b10:   open_cnt <= open_cnt + CNT_W'(1);
        2'b01:   open_cnt <= open_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue && issue_last;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      pkg_pending <= '0;
      overflow    <= 1'b0;
    end else begin
      case ({complete, pkg_done})
        2'b10: if (pkg_pending == CNT_W'(MAX_PKG)) overflow <= 1'b1;
               else pkg_pending <= pkg_pending + CNT_W'(1);
        2'b01: pkg_pending <= pkg_pending - CNT_W'(1);
        default: ;
      endcase
    end
  end

  rd_return_fifo #(.DEPTH(FIFO_DEPTH), .W(OUT_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (live_rising),
    .push      (vld_pipe[RD_LATENCY]),
    .push_data ({last_pipe[RD_LATENCY], odd_q, even_q}),
    .pop       (xfer),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
  assign out_last  = out_valid & head[OUT_W];

`ifdef HEADER_CHECK_EN
  logic at_head;

  always_ff @(posedge clk) begin
    if (init) begin
      at_head <= 1'b1;
      hdr_err <= 1'b0;
    end else if (xfer) begin
      at_head <= out_last;
      if (at_head && out_data[DATA_W-1:0] != HEADER_WORD) hdr_err <= 1'b1;
    end
  end
`else
  assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_read_control.sv
// Scoreboard bench for read_control: a latency-2 RAM model feeds the DUT, expected words are queued per package.
module tb_read_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1, live_rising = 1'b0, complete = 1'b0, out_ready = 1'b0;
  logic [9:0]  half = 10'd516;
  logic [14:0] depth = 15'd16384;
  logic [14:0] rd_addr;
  logic [15:0] even_q, odd_q;
  logic [31:0] out_data;
  logic        out_valid, out_last, overflow, hdr_err;
  logic [4:0]  pkg_pending;

  int checks = 0, failures = 0;
  logic [32:0] exp_q[$];
  logic [15:0] salt = 16'h0000;
  logic        hdr_mode = 1'b0;
  logic [14:0] bbase = '0;
  int          half_m = 516, depth_m = 16384;
  logic [14:0] a_d1 = '0, a_d2 = '0;

  always #5 clk = ~clk;

  read_control dut (
    .clk(clk), .rst(rst), .live_rising(live_rising), .complete(complete),
    .HALF_PACKAGE_LENGTH(half), .MEMORY_DEPTH(depth), .rd_addr(rd_addr),
    .even_q(even_q), .odd_q(odd_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .pkg_pending(pkg_pending),
    .overflow(overflow), .hdr_err(hdr_err)
  );

  function automatic logic [15:0] ram_even(input logic [14:0] a, input logic [15:0] s, input logic hm);
    if (hm && a == 15'd0) return 16'h1234;
    return {1'b0, a} ^ s;
  endfunction

  function automatic logic [15:0] ram_odd(input logic [14:0] a, input logic [15:0] s);
    return {1'b1, a} ^ {s[7:0], s[15:8]};
  endfunction

  // RAM model: data valid two clocks after the address is presented
  always @(posedge clk) begin
    a_d1 <= rd_addr;
    a_d2 <= a_d1;
  end
  assign even_q = ram_even(a_d2, salt, hdr_mode);
  assign odd_q  = ram_odd(a_d2, salt);

  // Stream monitor: scoreboard pop on every transfer, and hold check under backpressure
  initial begin
    logic        prev_stall;
    logic [32:0] prev_word, e;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (!out_valid || {out_last, out_data} !== prev_word) begin
          failures++;
          $display("FAIL stall_hold: got v=%b %h, want v=1 %h", out_valid, {out_last, out_data}, prev_word);
        end
      end
      prev_stall = out_valid && !out_ready && !rst && !live_rising;
      prev_word  = {out_last, out_data};
      if (out_valid && out_ready && !rst && !live_rising) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got %h, want no word", {out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            failures++;
            $display("FAIL word: got last/data %h, want %h", {out_last, out_data}, e);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_live(input int h, input int d);
    exp_q.delete();
    bbase = '0; half_m = h; depth_m = d;
    half = 10'(h); depth = 15'(d);
    live_rising = 1'b1;
    tick();
    live_rising = 1'b0;
  endtask

  task automatic push_pkg();
    logic [14:0] a;
    int nb;
    for (int i = 0; i < half_m; i++) begin
      a = bbase + 15'(i);
      exp_q.push_back({(i == half_m - 1), ram_odd(a, salt), ram_even(a, salt, hdr_mode)});
    end
    nb = int'(bbase) + half_m;
    bbase = (nb >= depth_m) ? 15'd0 : 15'(nb);
  endtask

  task automatic pulse_complete(input bit track);
    if (track) push_pkg();
    complete = 1'b1;
    tick();
    complete = 1'b0;
  endtask

  task automatic drain(input int budget, input bit rnd, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d words still expected after %0d cycles, want 0", name, exp_q.size(), n);
    end
  endtask

  task automatic check_pending(input logic [4:0] want, input string name);
    checks++;
    if (pkg_pending !== want) begin
      failures++;
      $display("FAIL %s: pkg_pending=%0d, want %0d", name, pkg_pending, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();
    checks++;
    if ({rd_addr, out_valid, out_last, out_data, pkg_pending, overflow, hdr_err} !== '0) begin
      failures++;
      $display("FAIL reset: addr=%h v=%b l=%b d=%h p=%0d ovf=%b hdr=%b, want all 0",
               rd_addr, out_valid, out_last, out_data, pkg_pending, overflow, hdr_err);
    end
  endtask

  task automatic test_single();
    do_live(516, 16384);
    out_ready = 1'b1;
    pulse_complete(1);
    check_pending(5'd1, "single_pending_up");
    drain(1200, 0, "single");
    tick(2);
    check_pending(5'd0, "single_pending_down");
  endtask

  task automatic test_back_to_back();
    int n = 0, cyc = 0, xf = 0;
    do_live(516, 16384);
    out_ready = 1'b1;
    repeat (3) pulse_complete(1);
    while (!out_valid && n < 50) begin tick(); n++; end
    while (xf < 1548 && cyc < 3000) begin
      if (out_valid && out_ready) xf++;
      cyc++;
      tick();
    end
    checks++;
    if (cyc !== 1548) begin
      failures++;
      $display("FAIL b2b_throughput: %0d cycles for %0d words, want 1548", cyc, xf);
    end
    drain(20, 0, "b2b");
    tick(2);
    check_pending(5'd0, "b2b_pending");
  endtask

  task automatic test_backpressure();
    salt = 16'hA55A;
    do_live(516, 16384);
    out_ready = 1'b0;
    repeat (2) pulse_complete(1);
    tick(20);
    checks++;
    if (rd_addr !== 15'd4 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_addr: rd_addr=%0d v=%b, want 4 v=1", rd_addr, out_valid);
    end
    drain(8000, 1, "random_ready");
    tick(2);
    check_pending(5'd0, "bp_pending");
  endtask

  task automatic test_wrap();
    salt = 16'h0F0F;
    do_live(516, 2000);
    out_ready = 1'b1;
    repeat (4) pulse_complete(1);
    drain(3000, 0, "wrap");
    tick(2);
    check_pending(5'd0, "wrap_pending");
  endtask

  task automatic test_overflow();
    do_live(516, 16384);
    out_ready = 1'b0;
    repeat (16) pulse_complete(0);
    check_pending(5'd16, "ovf_full");
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_early: overflow=%b, want 0", overflow);
    end
    pulse_complete(0);
    tick(3);
    check_pending(5'd16, "ovf_hold");
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: overflow=%b, want 1", overflow);
    end
    do_live(516, 16384);
    checks++;
    if (overflow !== 1'b0 || pkg_pending !== 5'd0) begin
      failures++;
      $display("FAIL ovf_clear: overflow=%b pending=%0d, want 0 0", overflow, pkg_pending);
    end
  endtask

  task automatic test_abort();
    int xf = 0, cyc = 0, seen = 0;
    salt = 16'h3C3C;
    do_live(516, 16384);
    out_ready = 1'b1;
    pulse_complete(1);
    while (xf < 200 && cyc < 1000) begin
      if (out_valid && out_ready) xf++;
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    salt = 16'h9669;
    do_live(516, 16384);
    checks++;
    if (out_valid !== 1'b0 || pkg_pending !== 5'd0) begin
      failures++;
      $display("FAIL abort: v=%b pending=%0d, want 0 0", out_valid, pkg_pending);
    end
    out_ready = 1'b1;
    repeat (30) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_stale: %0d valid cycles after abort, want 0", seen);
    end
    pulse_complete(1);
    drain(1200, 0, "post_abort");
  endtask

  task automatic test_header();
`ifdef HEADER_CHECK_EN
    salt = 16'h0000;
    hdr_mode = 1'b1;
    do_live(516, 16384);
    out_ready = 1'b1;
    pulse_complete(1);
    drain(1200, 0, "hdr");
    checks++;
    if (hdr_err !== 1'b1) begin
      failures++;
      $display("FAIL hdr_set: hdr_err=%b, want 1", hdr_err);
    end
    hdr_mode = 1'b0;
    do_live(516, 16384);
    checks++;
    if (hdr_err !== 1'b0) begin
      failures++;
      $display("FAIL hdr_clear: hdr_err=%b, want 0", hdr_err);
    end
`else
    checks++;
    if (hdr_err !== 1'b0) begin
      failures++;
      $display("FAIL hdr_tied: hdr_err=%b, want 0", hdr_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_overflow();
    test_abort();
    test_header();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
